logic_pod_rle_compressor: RTL and testbench

- Run-length compressor for the 16-channel logic pod capture path, one clock domain.
- Sits directly upstream of the 17-to-128-bit deserializer and drives its compress_out_valid / compress_out_format / compress_out_data inputs.
- Converts a stream of 16-bit samples into 17-bit words, each either a raw sample or a repeat count, so idle channels cost almost no FIFO bandwidth.

---
 rtl/logic_pod_rle_compressor.sv | 192 +++++++++++++++++++
 tb/tb_logic_pod_rle_compressor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/logic_pod_rle_compressor.sv
// logic_pod_rle_compressor
//   Run-length compressor for the 16-channel logic pod capture path.
//   It turns a stream of 16-bit samples into 17-bit words. Each word is
//   either a raw sample (RAW) or a repeat count for the previous sample
//   (RUN). A small output queue absorbs cycles that produce several words.
//
// Ports
//   clk                  capture clock
//   rst_n                asynchronous active-low reset
//   sample_valid         sample_data holds a new sample this cycle
//   sample_data[15:0]    logic pod sample, one bit per channel
//   flush                one-cycle pulse that closes the current run
//   compress_out_valid   head word valid this cycle (consumer never stalls)
//   compress_out_format  0 = RAW sample, 1 = RUN repeat count
//   compress_out_data    sample or repeat count; holds its value while idle
//   overflow             sticky flag: a queue write was dropped
module logic_pod_rle_compressor #(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   input  logic        flush,
   output logic        compress_out_valid,
   output logic        compress_out_format,
   output logic [15:0] compress_out_data,
   output logic        overflow
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
   localparam logic FMT_RAW = 1'b0;
   localparam logic FMT_RUN = 1'b1;

   typedef struct packed {
      logic        fmt;
      logic [15:0] data;
   } word_t;

   // ---------------------------------------------------------------
   // Run tracking
   // ---------------------------------------------------------------
   logic        have_prev;
   logic [15:0] prev_sample;
   logic [15:0] run_count;

   logic        is_new;
   logic        is_rep;
   logic [15:0] run_inc;
   logic [15:0] run_mid;   // run count after this cycle's sample, before flush
   logic [2:0]  w_vld;
   word_t       w [3];     // slot order: RUN(old run or saturated), RAW(new), RUN(flush)

   always_comb begin
      is_new  = sample_valid && (!have_prev || (sample_data != prev_sample));
      is_rep  = sample_valid && have_prev && (sample_data == prev_sample);
      run_inc = run_count + 16'd1;
      run_mid = run_count;
      w_vld   = '0;
      w[0]    = '0;
      w[1]    = '0;
      w[2]    = '0;
      if (is_new) begin
         w_vld[0] = (run_count != 16'd0);
         w[0]     = {FMT_RUN, run_count};
         w_vld[1] = 1'b1;
         w[1]     = {FMT_RAW, sample_data};
         run_mid  = '0;
      end else if (is_rep) begin
         // Report at the saturation point so the count never wraps.
         // The next repeat then starts a fresh count at 1.
         if (run_inc == 16'hFFFF) begin
            w_vld[0] = 1'b1;
            w[0]     = {FMT_RUN, 16'hFFFF};
            run_mid  = '0;
         end else begin
            run_mid  = run_inc;
         end
      end
      // Flush acts after the sample, so a repeat in the same cycle is
      // included in the reported count.
      if (flush && (run_mid != 16'd0)) begin
         w_vld[2] = 1'b1;
         w[2]     = {FMT_RUN, run_mid};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_prev   <= 1'b0;
         prev_sample <= '0;
         run_count   <= '0;
      end else begin
         if (is_new) prev_sample <= sample_data;
         if (flush) begin
            // Clearing have_prev makes the next sample come out RAW.
            have_prev <= 1'b0;
            run_count <= '0;
         end else begin
            run_count <= run_mid;
            if (is_new) have_prev <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Output queue: circular buffer with an occupancy count
   // ---------------------------------------------------------------
   word_t          mem [QUEUE_DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;

   logic           pop;
   logic [CW-1:0]  remain;
   logic [CW-1:0]  space;
   logic [CW-1:0]  n_acc;
   logic [2:0]     acc_vld;
   word_t          acc_word [3];
   logic           drop;
   logic [PW-1:0]  rd_next;
   logic           head_vld;
   word_t          head;

   always_comb begin
      pop         = (count != '0);
      remain      = count - CW'(pop);
      space       = DEPTH_C - remain;   // the pop frees its slot first
      rd_next     = rd_ptr + PW'(pop);
      n_acc       = '0;
      acc_vld     = '0;
      acc_word[0] = '0;
      acc_word[1] = '0;
      acc_word[2] = '0;
      drop        = 1'b0;
      // Compact the valid words into consecutive slots. Once space runs
      // out every later word is dropped too, so the stored order is kept.
      for (int i = 0; i < 3; i++) begin
         if (w_vld[i]) begin
            if (n_acc < space) begin
               acc_word[n_acc[1:0]] = w[i];
               acc_vld[n_acc[1:0]]  = 1'b1;
               n_acc                = n_acc + CW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
      // Head for the next cycle: oldest surviving entry, else the first
      // word written this cycle.
      head_vld = 1'b0;
      head     = '0;
      if (remain != '0) begin
         head_vld = 1'b1;
         head     = mem[rd_next];
      end else if (acc_vld[0]) begin
         head_vld = 1'b1;
         head     = acc_word[0];
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (acc_vld[j]) mem[wr_ptr + PW'(j)] <= acc_word[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr              <= '0;
         wr_ptr              <= '0;
         count               <= '0;
         compress_out_format <= 1'b0;
         compress_out_data   <= '0;
         overflow            <= 1'b0;
      end else begin
         rd_ptr <= rd_next;
         wr_ptr <= wr_ptr + PW'(n_acc);
         count  <= remain + n_acc;
         if (head_vld) begin
            compress_out_format <= head.fmt;
            compress_out_data   <= head.data;
         end
         if (drop) overflow <= 1'b1;
      end
   end

   assign compress_out_valid = (count != '0);

endmodule

// File: tb/tb_logic_pod_rle_compressor.sv
// Directed bench for logic_pod_rle_compressor. Inputs are driven 1 ns after
// the rising edge, and outputs are sampled at the same point.
module tb_logic_pod_rle_compressor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        flush;
   logic        compress_out_valid;
   logic        compress_out_format;
   logic [15:0] compress_out_data;
   logic        overflow;

   int vectors     = 0;
   int miscompares = 0;

   int          p, k, expw;
   logic        v5;
   logic        ef;
   logic [15:0] ed, smp;

   logic_pod_rle_compressor #(.QUEUE_DEPTH(4)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sample_valid        (sample_valid),
      .sample_data         (sample_data),
      .flush               (flush),
      .compress_out_valid  (compress_out_valid),
      .compress_out_format (compress_out_format),
      .compress_out_data   (compress_out_data),
      .overflow            (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic v, input logic f, input logic [15:0] d);
      vectors++;
      assert ({compress_out_valid, compress_out_format, compress_out_data} === {v, f, d})
      else begin
         miscompares++;
         $error("FAIL %s: observed v=%0b f=%0b d=%h, expected v=%0b f=%0b d=%h",
                tag, compress_out_valid, compress_out_format, compress_out_data, v, f, d);
      end
   endtask

   task automatic chk_valid(input string tag, input logic v);
      vectors++;
      assert (compress_out_valid === v)
      else begin
         miscompares++;
         $error("FAIL %s: observed valid=%0b, expected %0b", tag, compress_out_valid, v);
      end
   endtask

   task automatic chk_ovf(input string tag);
      vectors++;
      assert (overflow === 1'b0)
      else begin
         miscompares++;
         $error("FAIL %s: observed overflow=%0b, expected 0", tag, overflow);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic f);
      sample_valid = v;
      sample_data  = d;
      flush        = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; flush = 1'b0;
      #2;
      chk("reset_init", 1'b0, 1'b0, 16'h0000);
      chk_ovf("reset_init_ovf");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: async reset with two words queued and prev_sample = 1234
      drive(1'b1, 16'h5A5A, 1'b0); chk("t1_raw5a", 1'b1, 1'b0, 16'h5A5A);
      drive(1'b1, 16'h5A5A, 1'b0); chk("t1_rep",   1'b0, 1'b0, 16'h5A5A);
      drive(1'b1, 16'h1234, 1'b0); chk("t1_run1",  1'b1, 1'b1, 16'h0001);
      sample_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t1_async_rst", 1'b0, 1'b0, 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b1, 16'h1234, 1'b0); chk("t1_raw_after_rst", 1'b1, 1'b0, 16'h1234);
      drive(1'b0, 16'h0000, 1'b0); chk("t1_no_stale",      1'b0, 1'b0, 16'h1234);

      // 2: distinct samples, one cycle latency each
      drive(1'b1, 16'h0001, 1'b0); chk("t2_raw1", 1'b1, 1'b0, 16'h0001);
      drive(1'b1, 16'h0002, 1'b0); chk("t2_raw2", 1'b1, 1'b0, 16'h0002);
      drive(1'b1, 16'h0003, 1'b0); chk("t2_raw3", 1'b1, 1'b0, 16'h0003);
      drive(1'b0, 16'h0000, 1'b0); chk("t2_idle", 1'b0, 1'b0, 16'h0003);

      // 3: AAAA x6 then 5555
      drive(1'b1, 16'hAAAA, 1'b0); chk("t3_raw", 1'b1, 1'b0, 16'hAAAA);
      repeat (5) begin
         drive(1'b1, 16'hAAAA, 1'b0); chk("t3_rep", 1'b0, 1'b0, 16'hAAAA);
      end
      drive(1'b1, 16'h5555, 1'b0); chk("t3_run5",   1'b1, 1'b1, 16'h0005);
      drive(1'b0, 16'h0000, 1'b0); chk("t3_raw55",  1'b1, 1'b0, 16'h5555);
      drive(1'b0, 16'h0000, 1'b0); chk("t3_idle",   1'b0, 1'b0, 16'h5555);

      // 4: 00FF x65537 then 0000 (saturating run count)
      drive(1'b1, 16'h00FF, 1'b0); chk("t4_raw", 1'b1, 1'b0, 16'h00FF);
      for (int i = 2; i <= 65535; i++) drive(1'b1, 16'h00FF, 1'b0);
      chk("t4_pre_sat", 1'b0, 1'b0, 16'h00FF);
      drive(1'b1, 16'h00FF, 1'b0); chk("t4_run_ffff", 1'b1, 1'b1, 16'hFFFF);
      drive(1'b1, 16'h00FF, 1'b0); chk("t4_restart",  1'b0, 1'b1, 16'hFFFF);
      drive(1'b1, 16'h0000, 1'b0); chk("t4_run1",     1'b1, 1'b1, 16'h0001);
      drive(1'b0, 16'h0000, 1'b0); chk("t4_raw0",     1'b1, 1'b0, 16'h0000);
      chk_ovf("t4_ovf");

      // 5: A,A,B,B,... with random gaps: RAW A, RUN 1, RAW B, RUN 1, RAW A ...
      p = 0; k = 0;
      for (int c = 0; c < 1000; c++) begin
         v5  = ($urandom_range(0, 3) != 0);
         smp = (((p / 2) % 2) == 1) ? 16'h3C3C : 16'hC3C3;
         drive(v5, v5 ? smp : 16'h0000, 1'b0);
         if (v5) p++;
         if (compress_out_valid) begin
            ef = (k % 2) == 1;
            ed = ef ? 16'h0001 : ((((k / 2) % 2) == 1) ? 16'h3C3C : 16'hC3C3);
            chk("t5_word", 1'b1, ef, ed);
            k++;
         end
      end
      repeat (3) begin
         drive(1'b0, 16'h0000, 1'b0);
         if (compress_out_valid) begin
            ef = (k % 2) == 1;
            ed = ef ? 16'h0001 : ((((k / 2) % 2) == 1) ? 16'h3C3C : 16'hC3C3);
            chk("t5_drain", 1'b1, ef, ed);
            k++;
         end
      end
      expw = (p == 0) ? 0 : 1 + 2 * (((p + 1) / 2) - 1);
      vectors++;
      assert (k == expw)
      else begin
         miscompares++;
         $error("FAIL t5_word_count: observed %0d, expected %0d", k, expw);
      end
      chk_ovf("t5_ovf");
      // A complete trailing pair leaves a run of 1 pending; flush reports it.
      drive(1'b0, 16'h0000, 1'b1);
      if (p > 0 && (p % 2) == 0) chk("t5_flush_run", 1'b1, 1'b1, 16'h0001);
      else                       chk_valid("t5_flush_none", 1'b0);
      drive(1'b0, 16'h0000, 1'b0);

      // 6: flush in the same cycle as a repeat, then RAW again
      drive(1'b1, 16'h7777, 1'b0); chk("t6_raw",      1'b1, 1'b0, 16'h7777);
      drive(1'b1, 16'h7777, 1'b0); chk("t6_rep1",     1'b0, 1'b0, 16'h7777);
      drive(1'b1, 16'h7777, 1'b0); chk("t6_rep2",     1'b0, 1'b0, 16'h7777);
      drive(1'b1, 16'h7777, 1'b1); chk("t6_run3",     1'b1, 1'b1, 16'h0003);
      drive(1'b1, 16'h7777, 1'b0); chk("t6_raw_post", 1'b1, 1'b0, 16'h7777);
      drive(1'b0, 16'h0000, 1'b0); chk("t6_idle",     1'b0, 1'b0, 16'h7777);

      // Worst case: flush every cycle with alternating samples
      for (int i = 0; i < 20; i++) begin
         smp = ((i % 2) == 1) ? 16'h0F0F : 16'hF0F0;
         drive(1'b1, smp, 1'b1);
         chk("wc_raw", 1'b1, 1'b0, smp);
      end
      drive(1'b0, 16'h0000, 1'b0); chk("wc_idle", 1'b0, 1'b0, 16'h0F0F);
      chk_ovf("wc_ovf");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
